// File: rtl/bmem_line_arbiter.sv
`default_nettype none
// ============================================================================
// bmem_line_arbiter : round-robin I/D L2 line arbiter onto a 64-bit burst bmem
// Revision: 1.0 - initial release
// ============================================================================
module bmem_line_arbiter #(
  parameter int LINE_WIDTH = 256,
  parameter int BEAT_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           i_addr,
  input  logic                  i_read,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic [31:0]           d_addr,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic [31:0]           bmem_address,
  output logic                  bmem_read,
  output logic                  bmem_write,
  output logic [BEAT_WIDTH-1:0] bmem_wdata,
  input  logic [BEAT_WIDTH-1:0] bmem_rdata,
  input  logic                  bmem_resp,
  output logic [31:0]           busy_cycles
);

  localparam int BURST_LEN = LINE_WIDTH / BEAT_WIDTH;
  localparam int CNT_W     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_CMD   = 3'd1,
    RD_BEATS = 3'd2,
    WR_BEATS = 3'd3,
    WR_WAIT  = 3'd4,
    DONE     = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic                  last_d_q, last_d_d;
  logic                  gnt_d_q, gnt_d_d;
  logic [31:0]           addr_q, addr_d;
  logic [CNT_W-1:0]      beat_q, beat_d;
  logic [LINE_WIDTH-1:0] line_q, line_d;
  logic [LINE_WIDTH-1:0] i_line_q, i_line_d;
  logic [LINE_WIDTH-1:0] d_line_q, d_line_d;
  logic [31:0]           busy_q, busy_d;

  logic i_pend, d_pend, pick_d;

  assign i_pend = i_read;
  assign d_pend = d_read | d_write;
  // On a tie, D wins unless D was the most recent grant.
  assign pick_d = d_pend & (~i_pend | ~last_d_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      last_d_q <= 1'b0;
      gnt_d_q  <= 1'b0;
      addr_q   <= '0;
      beat_q   <= '0;
      line_q   <= '0;
      i_line_q <= '0;
      d_line_q <= '0;
      busy_q   <= '0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
      gnt_d_q  <= gnt_d_d;
      addr_q   <= addr_d;
      beat_q   <= beat_d;
      line_q   <= line_d;
      i_line_q <= i_line_d;
      d_line_q <= d_line_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    last_d_d = last_d_q;
    gnt_d_d  = gnt_d_q;
    addr_d   = addr_q;
    beat_d   = beat_q;
    line_d   = line_q;
    i_line_d = i_line_q;
    d_line_d = d_line_q;
    busy_d   = (state_q != IDLE) ? busy_q + 32'd1 : busy_q;

    unique case (state_q)
      IDLE: begin
        if (i_pend || d_pend) begin
          gnt_d_d  = pick_d;
          last_d_d = pick_d;
          addr_d   = (pick_d ? d_addr : i_addr) & ~32'h0000_001F;
          beat_d   = '0;
          // A simultaneous read+write from D is taken as a write.
          state_d  = (pick_d && d_write) ? WR_BEATS : RD_CMD;
        end
      end
      RD_CMD: state_d = RD_BEATS;
      RD_BEATS: begin
        if (bmem_resp) begin
          line_d[beat_q*BEAT_WIDTH +: BEAT_WIDTH] = bmem_rdata;
          beat_d = beat_q + CNT_W'(1);
          if (beat_q == LAST_BEAT) begin
            state_d = DONE;
            // Publish the finished line so rdata only changes on completion.
            if (gnt_d_q) d_line_d = line_d;
            else         i_line_d = line_d;
          end
        end
      end
      WR_BEATS: begin
        beat_d = beat_q + CNT_W'(1);
        if (beat_q == LAST_BEAT) state_d = WR_WAIT;
      end
      WR_WAIT: begin
        if (bmem_resp) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bmem_address = addr_q;
  assign bmem_read    = (state_q == RD_CMD);
  assign bmem_write   = (state_q == WR_BEATS);
  assign bmem_wdata   = bmem_write ? d_wdata[beat_q*BEAT_WIDTH +: BEAT_WIDTH] : '0;
  assign i_resp       = (state_q == DONE) & ~gnt_d_q;
  assign d_resp       = (state_q == DONE) &  gnt_d_q;
  assign i_rdata      = i_line_q;
  assign d_rdata      = d_line_q;
  assign busy_cycles  = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_bmem_line_arbiter.sv
`default_nettype none
// ============================================================================
// tb_bmem_line_arbiter : directed self-checking bench for bmem_line_arbiter
// Revision: 1.0 - initial release
// ============================================================================
module tb_bmem_line_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  i_addr, d_addr;
  logic         i_read, d_read, d_write;
  logic [255:0] i_rdata, d_rdata, d_wdata;
  logic         i_resp, d_resp;
  logic [31:0]  bmem_address;
  logic         bmem_read, bmem_write, bmem_resp;
  logic [63:0]  bmem_wdata, bmem_rdata;
  logic [31:0]  busy_cycles;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t0;
  int busy0;
  int rd_seen = 0;
  int both_hi = 0;
  int resp_seen;

  bmem_line_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .i_addr       (i_addr),
    .i_read       (i_read),
    .i_rdata      (i_rdata),
    .i_resp       (i_resp),
    .d_addr       (d_addr),
    .d_read       (d_read),
    .d_write      (d_write),
    .d_wdata      (d_wdata),
    .d_rdata      (d_rdata),
    .d_resp       (d_resp),
    .bmem_address (bmem_address),
    .bmem_read    (bmem_read),
    .bmem_write   (bmem_write),
    .bmem_wdata   (bmem_wdata),
    .bmem_rdata   (bmem_rdata),
    .bmem_resp    (bmem_resp),
    .busy_cycles  (busy_cycles)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bmem_read)         rd_seen++;
    if (i_resp && d_resp)  both_hi++;
  end

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Plays the memory side of one read burst; returns with the DUT in DONE.
  task automatic serve_read(input logic [63:0] b0, input logic [63:0] b1,
                            input logic [63:0] b2, input logic [63:0] b3,
                            input int gap);
    logic [63:0] b [4];
    int n;
    b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;
    n = 0;
    while (bmem_read !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("rd_cmd_seen", bmem_read, 1'b1);
    tick();
    chk("rd_cmd_one_cycle", bmem_read, 1'b0);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) repeat (gap) tick();
      bmem_resp  = 1'b1;
      bmem_rdata = b[k];
      tick();
      bmem_resp  = 1'b0;
      bmem_rdata = '0;
    end
  endtask

  // Checks the four write beats, then acks after `waits` idle cycles in WR_WAIT.
  task automatic serve_write(input logic [255:0] line, input int waits, input logic spurious);
    tick();
    for (int k = 0; k < 4; k++) begin
      chk("wr_beat_valid", bmem_write, 1'b1);
      chk("wr_beat_data", bmem_wdata, line[64*k +: 64]);
      chk("wr_no_read", bmem_read, 1'b0);
      bmem_resp = spurious && (k == 1 || k == 2);
      tick();
    end
    bmem_resp = 1'b0;
    chk("wr_wait_bus_quiet", bmem_write, 1'b0);
    repeat (waits) begin
      chk("wr_no_early_resp", d_resp, 1'b0);
      tick();
    end
    bmem_resp = 1'b1;
    tick();
    bmem_resp = 1'b0;
    chk("wr_dresp", d_resp, 1'b1);
    chk("wr_no_iresp", i_resp, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    i_addr = '0; i_read = 1'b0;
    d_addr = '0; d_read = 1'b0; d_write = 1'b0; d_wdata = '0;
    bmem_rdata = '0; bmem_resp = 1'b0;
    tick(); tick();

    // Reset state
    chk("rst_outputs", {bmem_read, bmem_write, i_resp, d_resp}, 4'b0);
    chk("rst_addr", bmem_address, 32'h0);
    chk("rst_busy", busy_cycles, 32'h0);
    chk("rst_irdata", i_rdata, 256'h0);
    chk("rst_wdata", bmem_wdata, 64'h0);
    rst = 1'b1;
    tick();

    // Single I read: resp lands 6 edges after the request (7th cycle)
    t0 = cyc;
    i_addr = 32'h4000_0014; i_read = 1'b1;
    serve_read(64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
               64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444, 0);
    chk("t1_addr", bmem_address, 32'h4000_0000);
    chk("t1_latency", cyc - t0, 6);
    chk("t1_iresp", i_resp, 1'b1);
    chk("t1_dresp", d_resp, 1'b0);
    chk("t1_line", i_rdata, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                             64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
    i_read = 1'b0;
    tick();
    chk("t1_resp_pulse", i_resp, 1'b0);
    chk("t1_busy", busy_cycles, 32'd6);

    // D write with spurious bmem_resp during the beats
    busy0 = busy_cycles;
    d_addr = 32'h4000_1020; d_write = 1'b1;
    d_wdata = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
               64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
    serve_write(d_wdata, 1, 1'b1);
    chk("t2_addr", bmem_address, 32'h4000_1020);
    d_write = 1'b0;
    tick();
    chk("t2_resp_pulse", d_resp, 1'b0);
    chk("t2_busy", busy_cycles - busy0, 7);

    // Tie arbitration after a fresh reset: D, then I, then D again
    rst = 1'b0; tick(); rst = 1'b1; tick();
    i_addr = 32'h4000_2040; d_addr = 32'h4000_307F;
    i_read = 1'b1; d_read = 1'b1;
    serve_read(64'hD1, 64'hD2, 64'hD3, 64'hD4, 0);
    chk("tie1_addr", bmem_address, 32'h4000_3060);
    chk("tie1_dresp", {d_resp, i_resp}, 2'b10);
    chk("tie1_line", d_rdata, {64'hD4, 64'hD3, 64'hD2, 64'hD1});
    d_read = 1'b0;
    serve_read(64'hA1, 64'hA2, 64'hA3, 64'hA4, 0);
    chk("tie2_addr", bmem_address, 32'h4000_2040);
    chk("tie2_iresp", {d_resp, i_resp}, 2'b01);
    chk("tie2_line", i_rdata, {64'hA4, 64'hA3, 64'hA2, 64'hA1});
    chk("tie2_d_hold", d_rdata, {64'hD4, 64'hD3, 64'hD2, 64'hD1});
    i_read = 1'b0;
    tick();
    i_addr = 32'h4000_5500; d_addr = 32'h4000_4000;
    i_read = 1'b1; d_read = 1'b1;
    serve_read(64'hE1, 64'hE2, 64'hE3, 64'hE4, 0);
    chk("tie3_addr", bmem_address, 32'h4000_4000);
    chk("tie3_dresp", {d_resp, i_resp}, 2'b10);
    chk("tie3_i_hold", i_rdata, {64'hA4, 64'hA3, 64'hA2, 64'hA1});
    d_read = 1'b0;
    serve_read(64'hF1, 64'hF2, 64'hF3, 64'hF4, 0);
    chk("tie4_iresp", {d_resp, i_resp}, 2'b01);
    i_read = 1'b0;
    tick();

    // Read with 3-cycle gaps between beats
    t0 = cyc;
    i_addr = 32'h4000_5008; i_read = 1'b1;
    serve_read(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
               64'h0F0F_0F0F_0F0F_0F0F, 64'hF0F0_F0F0_F0F0_F0F0, 3);
    chk("gap_addr", bmem_address, 32'h4000_5000);
    chk("gap_latency", cyc - t0, 15);
    chk("gap_iresp", i_resp, 1'b1);
    chk("gap_line", i_rdata, {64'hF0F0_F0F0_F0F0_F0F0, 64'h0F0F_0F0F_0F0F_0F0F,
                              64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF});
    i_read = 1'b0;
    tick();

    // Async reset during beat 2 of a read
    i_addr = 32'h4000_6000; i_read = 1'b1;
    tick(); tick();
    for (int k = 0; k < 2; k++) begin
      bmem_resp = 1'b1; bmem_rdata = 64'h77 + 64'(k);
      tick();
    end
    bmem_rdata = 64'h99;
    #2 rst = 1'b0;
    #1;
    chk("arst_addr", bmem_address, 32'h0);
    chk("arst_busy", busy_cycles, 32'h0);
    chk("arst_irdata", i_rdata, 256'h0);
    chk("arst_ctrl", {bmem_read, bmem_write, i_resp, d_resp}, 4'b0);
    bmem_resp = 1'b0; bmem_rdata = '0; i_read = 1'b0;
    tick(); tick();
    rst = 1'b1;
    resp_seen = 0;
    repeat (8) begin
      tick();
      if (i_resp || d_resp) resp_seen++;
    end
    chk("arst_no_resp", resp_seen, 0);
    t0 = cyc;
    i_addr = 32'h4000_7000; i_read = 1'b1;
    serve_read(64'h5, 64'h6, 64'h7, 64'h8, 0);
    chk("arst_recover_lat", cyc - t0, 6);
    chk("arst_recover_line", i_rdata, {64'h8, 64'h7, 64'h6, 64'h5});
    chk("arst_recover_resp", i_resp, 1'b1);
    i_read = 1'b0;
    tick();

    // d_read and d_write together behave as a write
    busy0 = busy_cycles;
    rd_seen = 0;
    d_addr = 32'h4000_8010; d_read = 1'b1; d_write = 1'b1;
    d_wdata = {64'h4, 64'h3, 64'h2, 64'h1};
    serve_write(d_wdata, 2, 1'b0);
    chk("rw_addr", bmem_address, 32'h4000_8000);
    d_read = 1'b0; d_write = 1'b0;
    tick();
    chk("rw_busy", busy_cycles - busy0, 8);
    chk("rw_no_bmem_read", rd_seen, 0);
    chk("never_both_resp", both_hi, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bmem_line_arbiter.md
Name: bmem_line_arbiter

Overview:
- Sits between the two L2 caches (instruction and data) and the burst memory port of `mp4`.
- Arbitrates whole-cacheline requests from the two caches onto the single `bmem` burst interface.
- Serialises and deserialises each 256-bit line into 64-bit beats.
- Returns one-cycle line responses to the requesting cache.

Parameters:
- LINE_WIDTH, 256, cacheline width in bits on the cache side.
- BEAT_WIDTH, 64, bmem data width per beat.
- BURST_LEN, LINE_WIDTH/BEAT_WIDTH (4), beats per line; derived, not overridable.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-low (block in reset while rst==0)
- i_addr  in  32  I-L2 line address
- i_read  in  1  I-L2 line read request
- i_rdata  out  LINE_WIDTH  line data to I-L2
- i_resp  out  1  I-L2 completion pulse
- d_addr  in  32  D-L2 line address
- d_read  in  1  D-L2 line read request
- d_write  in  1  D-L2 line write request
- d_wdata  in  LINE_WIDTH  D-L2 writeback line
- d_rdata  out  LINE_WIDTH  line data to D-L2
- d_resp  out  1  D-L2 completion pulse
- bmem_address  out  32  burst address, line-aligned
- bmem_read  out  1  burst read command
- bmem_write  out  1  burst write beat valid
- bmem_wdata  out  BEAT_WIDTH  write beat
- bmem_rdata  in  BEAT_WIDTH  read beat
- bmem_resp  in  1  read beat valid / write-done pulse
- busy_cycles  out  32  perf counter: cycles not in IDLE

Behaviour:
- Reset (rst==0, async):
  - state=IDLE; last_grant=I.
  - All outputs 0, including line buffer, beat counter and busy_cycles.
  - Reset mid-transaction abandons the burst; no resp is issued afterwards.
- Request rules:
  - Caches hold addr/read/write/wdata stable from assertion until their resp pulse.
  - d_read and d_write both high is illegal; the block treats it as a write.
- Arbitration, evaluated only in IDLE:
  - If both ports are pending, grant the port opposite last_grant. After reset D wins the first tie.
  - If only one port is pending, grant it.
  - last_grant updates on grant.
  - Requests arriving during a transaction wait; there is no preemption.
- Address: bmem_address = granted addr with bits[4:0] forced to 0. It is held constant for the whole transaction.
- States:
  - IDLE -> RD_CMD on a read grant; IDLE -> WR_BEATS on a write grant. The grant takes one cycle; the bmem command starts the following cycle.
  - RD_CMD: bmem_read=1 for exactly one cycle, then -> RD_BEATS.
  - RD_BEATS:
    - On each cycle with bmem_resp=1, store bmem_rdata into line slice [64*k +: 64], k = beat counter 0..3, then increment k.
    - Gaps between beats are allowed.
    - After beat 3 -> DONE.
  - WR_BEATS:
    - bmem_write=1 for exactly BURST_LEN consecutive cycles; bmem_wdata = d_wdata[64*k +: 64], k=0..3.
    - After beat 3 -> WR_WAIT.
  - WR_WAIT: deassert bmem_write; wait for a bmem_resp pulse -> DONE.
  - DONE:
    - Assert the granted port's resp for exactly one cycle.
    - For reads, rdata holds the assembled line in that cycle and stays stable until the next read completes.
    - Next state is IDLE.
- Spurious bmem_resp in IDLE, RD_CMD or WR_BEATS is ignored.
- i_resp and d_resp are never high in the same cycle.
- busy_cycles increments every cycle state!=IDLE and wraps at 2^32.
- Minimum read latency, request to resp: 1 (grant) + 1 (cmd) + 4 (beats) + 1 (done) = 7 cycles with back-to-back beats.

Test Plan:
- Single I read, addr 0x40000014, beats 0x11..,0x22..,0x33..,0x44.. back-to-back:
  - bmem_address=0x40000000, bmem_read high 1 cycle.
  - i_resp at cycle 7; i_rdata = {0x44..,0x33..,0x22..,0x11..}.
- D write, addr 0x40001020, d_wdata = {0xDDDD..,0xCCCC..,0xBBBB..,0xAAAA..}:
  - Four consecutive bmem_write beats AA,BB,CC,DD.
  - d_resp exactly 1 cycle after the bmem_resp pulse.
- Simultaneous i_read and d_read right after reset:
  - D is served first, then I.
  - On a third tie after both complete, D is served again (alternation I then D holds).
- Read beats with 3-cycle gaps between bmem_resp pulses:
  - Line assembled correctly; resp delayed accordingly.
  - Spurious bmem_resp during WR_BEATS does not advance state.
- Assert rst=0 during beat 2 of a read:
  - Outputs go 0 immediately (async), with no i_resp/d_resp.
  - After release, a new request completes normally.
- d_read and d_write both high: write sequence issued, bmem_read never asserted; busy_cycles equals cycles spent outside IDLE.
